// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver for a common-anode
// display. A frame of N_DIGITS hex digits is captured into shadow registers
// at each frame start and scanned out one digit per refresh slot
// (2^DIV_WIDTH clocks). All display outputs are registered.
//
// Optional feature: define SEG_SCAN_DIM_EN to enable PWM dimming, where the
// digit is lit while the top four prescaler bits are <= the captured
// brightness. Without it the brightness port is accepted but ignored.
module seg_scan_driver #(
    parameter int N_DIGITS  = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic [3:0]              brightness,
    output logic [N_DIGITS-1:0]     anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    // Scan position
    logic [DIV_WIDTH-1:0]  pre_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  load_pending;

    // Frame captured at frame start; the scan only ever reads these
    logic [4*N_DIGITS-1:0] shadow_digits;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_blank;

    // Decoded control
    logic                  slot_tick;
    logic                  frame_wrap;
    logic                  load_now;
    logic                  pwm_on;
    logic                  lit;
    logic [3:0]            cur_digit;

    // Next values of the registered outputs
    logic [N_DIGITS-1:0]   anode_nx;
    logic [6:0]            seg_nx;
    logic                  dp_nx;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] pattern;
        pattern = 7'h7F;
        case (value)
            4'h0: pattern = 7'b1000000;
            4'h1: pattern = 7'b1111001;
            4'h2: pattern = 7'b0100100;
            4'h3: pattern = 7'b0110000;
            4'h4: pattern = 7'b0011001;
            4'h5: pattern = 7'b0010010;
            4'h6: pattern = 7'b0000010;
            4'h7: pattern = 7'b1111000;
            4'h8: pattern = 7'b0000000;
            4'h9: pattern = 7'b0010000;
            4'hA: pattern = 7'b0001000;
            4'hB: pattern = 7'b0000011;
            4'hC: pattern = 7'b1000110;
            4'hD: pattern = 7'b0100001;
            4'hE: pattern = 7'b0000110;
            4'hF: pattern = 7'b0001110;
            default: pattern = 7'h7F;
        endcase
        return pattern;
    endfunction

    assign slot_tick  = en && (pre_cnt == '1);
    assign frame_wrap = slot_tick && (idx == LAST_IDX);
    // The post-reset load and a frame wrap can coincide; either way it is a
    // single load and a single frame_tick.
    assign load_now   = en && (load_pending || frame_wrap);

`ifdef SEG_SCAN_DIM_EN
    logic [3:0] shadow_bright;

    // Capture the brightness with the rest of the frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_bright <= '0;
        end else if (load_now) begin
            shadow_bright <= brightness;
        end
    end

    assign pwm_on = (pre_cnt[DIV_WIDTH-1 -: 4] <= shadow_bright);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    // Select and decode the digit currently addressed by idx
    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        cur_digit = shadow_digits[4*idx +: 4];
        // Stay dark on the load cycle so the first digit shown after reset
        // is already the freshly captured frame, not the cleared shadows.
        lit       = en && !load_pending && !shadow_blank[idx] && pwm_on;
        anode_nx  = '1;
        seg_nx    = 7'h7F;
        dp_nx     = 1'b1;
        if (lit) begin
            anode_nx = ~(N_DIGITS'(1) << idx);
            seg_nx   = hex_to_seg(cur_digit);
            dp_nx    = ~shadow_dp[idx];
        end
    end

    // Prescaler, digit index and pending-load flag; frozen while en is low
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments
        // so every register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            pre_cnt      <= '0;
            idx          <= '0;
            load_pending <= 1'b1;
        end else if (en) begin
            pre_cnt <= pre_cnt + DIV_WIDTH'(1);
            if (slot_tick) begin
                // Explicit wrap so non-power-of-two digit counts skip unused codes
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            if (load_now) begin
                load_pending <= 1'b0;
            end
        end
    end

    // Shadow frame registers, loaded only at frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
        end else if (load_now) begin
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
            shadow_blank  <= blank_in;
        end
    end

    // Registered output stage driving the display pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anode      <= '1;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            anode      <= anode_nx;
            seg        <= seg_nx;
            dp         <= dp_nx;
            frame_tick <= load_now;
        end
    end

endmodule
